bcd_display_scanner: RTL and testbench

Time-multiplexing scanner that drives the BCD-to-7-segment decoder from a multi-digit BCD value. It holds a frame-synchronised copy of the value and presents one digit nibble at a time on `b3..b0` (decoder inputs). It drives a one-hot digit enable for the common-anode/cathode switches, with a guard interval against ghosting and optional leading-zero blanking. It sits directly upstream of the decoder; the decoder's `a..g` outputs go to the shared segment lines.

---
 rtl/bcd_display_scanner.sv | 122 ++++++++++++
 tb/tb_bcd_display_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD display scanner: frame-synchronised value capture,
// one digit nibble per slot, guarded one-hot digit enables, leading-zero blanking.
module bcd_display_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic                    b0,
  output logic                    b1,
  output logic                    b2,
  output logic                    b3,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW = $clog2(NUM_DIGITS);

  logic [CW-1:0]         cnt, cnt_nxt;
  logic [SW-1:0]         slot, slot_nxt;
  logic [DW-1:0]         disp, disp_nxt;
  logic [DW-1:0]         pend, pend_nxt;
  logic                  pending_nxt;
  logic                  wrap;
  logic [3:0]            nib_q, nib_nxt;
  logic [NUM_DIGITS-1:0] digit_en_nxt;
  logic                  frame_start_nxt;
  logic [NUM_DIGITS-1:0] blanked;
  logic                  tail_zero;

  // State register; outputs are registered from next-state values so they
  // line up with cnt/slot in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      slot        <= '0;
      disp        <= '0;
      pend        <= '0;
      pending     <= 1'b0;
      nib_q       <= '0;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      slot        <= slot_nxt;
      disp        <= disp_nxt;
      pend        <= pend_nxt;
      pending     <= pending_nxt;
      nib_q       <= nib_nxt;
      digit_en    <= digit_en_nxt;
      frame_start <= frame_start_nxt;
    end
  end

  // Next-state: prescaler, slot counter and load/transfer of the display value
  always_comb begin
    cnt_nxt     = cnt;
    slot_nxt    = slot;
    disp_nxt    = disp;
    pend_nxt    = pend;
    pending_nxt = pending;
    wrap        = 1'b0;

    if (!enable) begin
      cnt_nxt  = '0;
      slot_nxt = '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt_nxt = '0;
      if (slot == SW'(NUM_DIGITS - 1)) begin
        slot_nxt = '0;
        wrap     = 1'b1;
      end else begin
        slot_nxt = slot + SW'(1);
      end
    end else begin
      cnt_nxt = cnt + CW'(1);
    end

    if (load) pend_nxt = digits_in;

    // A load on a transfer edge bypasses pend so it is shown in this slot 0
    if ((wrap || !enable) && load) begin
      disp_nxt    = digits_in;
      pending_nxt = 1'b0;
    end else if ((wrap || !enable) && pending) begin
      disp_nxt    = pend;
      pending_nxt = 1'b0;
    end else if (load) begin
      pending_nxt = 1'b1;
    end
  end

  // Leading-zero mask: digit i blanked when it and all higher digits are zero
  always_comb begin
    blanked   = '0;
    tail_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      tail_zero  = tail_zero && (disp_nxt[4*i +: 4] == 4'd0);
      blanked[i] = blank_lz && tail_zero;
    end
  end

  // Output decode for the upcoming cycle
  always_comb begin
    nib_nxt         = disp_nxt[{slot_nxt, 2'b00} +: 4];
    digit_en_nxt    = '0;
    frame_start_nxt = wrap;
    if (enable && (32'(cnt_nxt) >= GUARD) && !blanked[slot_nxt])
      digit_en_nxt[slot_nxt] = 1'b1;
  end

  assign {b3, b2, b1, b0} = nib_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1.
module tb_bcd_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n, enable, load, blank_lz;
  logic [15:0] digits_in;
  logic        b0, b1, b2, b3;
  logic [3:0]  digit_en;
  logic        frame_start, pending;
  logic [3:0]  nib;
  int          vectors = 0;
  int          miscompares = 0;

  assign nib = {b3, b2, b1, b0};

  bcd_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .digits_in(digits_in), .blank_lz(blank_lz),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .digit_en(digit_en), .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance to the next frame_start (at least one cycle), bounded
  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: frame_start never seen in %0d cycles", tag, n);
    end
  endtask

  task automatic test_reset();
    int n;
    vectors++;
    if ({nib, digit_en, frame_start, pending} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_init: nib=%h en=%b fs=%b pend=%b want all 0", nib, digit_en, frame_start, pending);
    end
    rst_n = 1'b1; enable = 1'b1;
    repeat (5) tick();
    load = 1'b1; digits_in = 16'h9999;
    tick();
    load = 1'b0;
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_pending: pending=%b want 1", pending);
    end
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({nib, digit_en, frame_start, pending} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_async: nib=%h en=%b fs=%b pend=%b want all 0", nib, digit_en, frame_start, pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL reset_first_frame: cycles=%0d want 16", n);
    end
    vectors++;
    if (nib !== 4'h0 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_discard: nib=%h pend=%b want nib=0 pend=0", nib, pending);
    end
  endtask

  task automatic test_load_scan();
    logic [15:0] val = 16'h1234;
    logic [3:0]  exp_en;
    blank_lz = 1'b0;
    tick();
    load = 1'b1; digits_in = val;
    tick();
    load = 1'b0;
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++;
      $display("FAIL load_pending: pending=%b want 1", pending);
    end
    wait_frame("load_wait");
    vectors++;
    if (pending !== 1'b0) begin
      miscompares++;
      $display("FAIL load_pending_clear: pending=%b want 0", pending);
    end
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (s != 0 || c != 0) tick();
        exp_en = (c >= 1) ? 4'(1 << s) : 4'b0;
        vectors++;
        if (nib !== val[4*s +: 4] || digit_en !== exp_en || frame_start !== (s == 0 && c == 0)) begin
          miscompares++;
          $display("FAIL scan_1234 s%0d c%0d: nib=%h en=%b fs=%b want nib=%h en=%b", s, c, nib, digit_en, frame_start, val[4*s +: 4], exp_en);
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    logic [3:0]  masks [2] = '{4'b0011, 4'b0001};
    logic [15:0] val;
    logic [3:0]  exp_en;
    blank_lz = 1'b1;
    for (int t = 0; t < 2; t++) begin
      val = vals[t];
      load = 1'b1; digits_in = val;
      tick();
      load = 1'b0;
      wait_frame("blank_wait");
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 4; c++) begin
          if (s != 0 || c != 0) tick();
          exp_en = (c >= 1 && masks[t][s]) ? 4'(1 << s) : 4'b0;
          vectors++;
          if (nib !== val[4*s +: 4] || digit_en !== exp_en) begin
            miscompares++;
            $display("FAIL blank_%h s%0d c%0d: nib=%h en=%b want nib=%h en=%b", val, s, c, nib, digit_en, val[4*s +: 4], exp_en);
          end
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_en;
    tick();
    tick();
    load = 1'b1; digits_in = 16'h1111;
    tick();
    digits_in = 16'h2222;
    tick();
    load = 1'b0;
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++;
      $display("FAIL overwrite_pending: pending=%b want 1", pending);
    end
    wait_frame("overwrite_wait");
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (s != 0 || c != 0) tick();
        exp_en = (c >= 1) ? 4'(1 << s) : 4'b0;
        vectors++;
        if (nib !== 4'h2 || digit_en !== exp_en) begin
          miscompares++;
          $display("FAIL overwrite s%0d c%0d: nib=%h en=%b want nib=2 en=%b", s, c, nib, digit_en, exp_en);
        end
      end
    end
    load = 1'b1; digits_in = 16'h3333;
    tick();
    load = 1'b0;
    vectors++;
    if (frame_start !== 1'b1 || nib !== 4'h3 || pending !== 1'b0 || digit_en !== 4'b0) begin
      miscompares++;
      $display("FAIL collision: fs=%b nib=%h pend=%b en=%b want fs=1 nib=3 pend=0 en=0000", frame_start, nib, pending, digit_en);
    end
  endtask

  task automatic test_enable_gating();
    int n;
    repeat (8) tick();
    load = 1'b1; digits_in = 16'h4567;
    tick();
    load = 1'b0;
    vectors++;
    if (pending !== 1'b1 || digit_en !== 4'b0100 || nib !== 4'h3) begin
      miscompares++;
      $display("FAIL gate_pre: pend=%b en=%b nib=%h want pend=1 en=0100 nib=3", pending, digit_en, nib);
    end
    enable = 1'b0;
    tick();
    vectors++;
    if (digit_en !== 4'b0 || pending !== 1'b0 || nib !== 4'h7 || frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL gate_off: en=%b pend=%b nib=%h fs=%b want en=0000 pend=0 nib=7 fs=0", digit_en, pending, nib, frame_start);
    end
    enable = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        vectors++;
        if (digit_en !== 4'b0001 || nib !== 4'h7) begin
          miscompares++;
          $display("FAIL gate_restart: en=%b nib=%h want en=0001 nib=7", digit_en, nib);
        end
      end
    end while (frame_start !== 1'b1 && n < 40);
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL gate_first_frame: cycles=%0d want 16", n);
    end
  endtask

  task automatic test_invalid_bcd();
    logic [15:0] val = 16'hFA00;
    logic [3:0]  exp_en;
    load = 1'b1; digits_in = val;
    tick();
    load = 1'b0;
    wait_frame("invalid_wait");
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (s != 0 || c != 0) tick();
        exp_en = (c >= 1) ? 4'(1 << s) : 4'b0;
        vectors++;
        if (nib !== val[4*s +: 4] || digit_en !== exp_en) begin
          miscompares++;
          $display("FAIL invalid s%0d c%0d: nib=%h en=%b want nib=%h en=%b", s, c, nib, digit_en, val[4*s +: 4], exp_en);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; blank_lz = 1'b0; digits_in = '0;
    repeat (2) tick();
    test_reset();
    test_load_scan();
    test_blanking();
    test_back_to_back();
    test_enable_gating();
    test_invalid_bcd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
